// File: rtl/hazard_stall_ctrl.sv
// Load-use and load-branch hazard detection for the 5-stage MIPS pipeline.
// Drives PC/IF-ID enables, ID/EX bubble and IF/ID squash; keeps saturating event counters.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic [4:0]       RegWriteAddr_ex,
    input  logic             MemRead_mem,
    input  logic [4:0]       RegWriteAddr_mem,
    input  logic [4:0]       RsAddr_id,
    input  logic [4:0]       RtAddr_id,
    input  logic             UsesRt_id,
    input  logic             Branch_id,
    input  logic             BranchTaken_id,
    input  logic             Jump_id,
    input  logic             Hold,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXFlush,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [0:0] {
        StRun,
        StBstall
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
    logic hit_ex, hit_mem;
    logic stall;

    // RegWrite_ex is implied by MemRead_ex for a load; only the load flag matters here.
    logic unused_regwrite;
    assign unused_regwrite = RegWrite_ex;

    // Register 0 is hard-wired to zero and never creates a dependency.
    always_comb begin
        rs_hit_ex  = (RegWriteAddr_ex != 5'd0) && (RegWriteAddr_ex == RsAddr_id);
        rt_hit_ex  = (RegWriteAddr_ex != 5'd0) && UsesRt_id && (RegWriteAddr_ex == RtAddr_id);
        rs_hit_mem = (RegWriteAddr_mem != 5'd0) && (RegWriteAddr_mem == RsAddr_id);
        rt_hit_mem = (RegWriteAddr_mem != 5'd0) && UsesRt_id && (RegWriteAddr_mem == RtAddr_id);
        hit_ex     = MemRead_ex && (rs_hit_ex || rt_hit_ex);
        hit_mem    = MemRead_mem && (rs_hit_mem || rt_hit_mem);
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IDEXFlush = 1'b0;
        IFIDFlush = 1'b0;

        if (rst) begin
            state_d = StRun;
        end else if (Hold) begin
            // Freeze everything, including a pending second branch stall.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hit_ex) begin
                        stall = 1'b1;
                        if (Branch_id) begin
                            state_d = StBstall;
                        end
                    end else if (Branch_id && hit_mem) begin
                        stall = 1'b1;
                    end
                end
                StBstall: begin
                    stall   = 1'b1;
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase

            if (stall) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end else begin
                IFIDFlush = (Branch_id && BranchTaken_id) || Jump_id;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (IDEXFlush && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (IFIDFlush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a second instance with CNT_W=2 checks saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       MemRead_ex, RegWrite_ex, MemRead_mem;
    logic [4:0] RegWriteAddr_ex, RegWriteAddr_mem, RsAddr_id, RtAddr_id;
    logic       UsesRt_id, Branch_id, BranchTaken_id, Jump_id, Hold;

    logic        PCWrite, IFIDWrite, IDEXFlush, IFIDFlush;
    logic [15:0] StallCnt, FlushCnt;
    logic        s_PCWrite, s_IFIDWrite, s_IDEXFlush, s_IFIDFlush;
    logic [1:0]  s_StallCnt, s_FlushCnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
        .MemRead_mem(MemRead_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
        .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .UsesRt_id(UsesRt_id),
        .Branch_id(Branch_id), .BranchTaken_id(BranchTaken_id), .Jump_id(Jump_id), .Hold(Hold),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_stall_ctrl #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
        .MemRead_mem(MemRead_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
        .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .UsesRt_id(UsesRt_id),
        .Branch_id(Branch_id), .BranchTaken_id(BranchTaken_id), .Jump_id(Jump_id), .Hold(Hold),
        .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEXFlush(s_IDEXFlush),
        .IFIDFlush(s_IFIDFlush), .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {PCWrite, IFIDWrite, IDEXFlush, IFIDFlush}.
    task automatic chk_out(input string tag, input logic [3:0] exp);
        #1;
        check_eq(tag, {28'd0, PCWrite, IFIDWrite, IDEXFlush, IFIDFlush}, {28'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead_ex = 1'b0; RegWrite_ex = 1'b0; RegWriteAddr_ex = 5'd0;
        MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;
        RsAddr_id = 5'd0; RtAddr_id = 5'd0; UsesRt_id = 1'b0;
        Branch_id = 1'b0; BranchTaken_id = 1'b0; Jump_id = 1'b0; Hold = 1'b0;
    endtask

    task automatic ex_lw(input logic [4:0] rd);
        MemRead_ex = 1'b1; RegWrite_ex = 1'b1; RegWriteAddr_ex = rd;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        ex_lw(5'd1);
        RsAddr_id = 5'd1;
        chk_out("rst_outputs", 4'b1100);
        step();
        rst = 1'b0;
        idle();
        #1;
        check_eq("rst_stallcnt", 32'(StallCnt), 32'd0);
        check_eq("rst_flushcnt", 32'(FlushCnt), 32'd0);

        // Load-use: one bubble, then released.
        ex_lw(5'd1); RsAddr_id = 5'd1;
        chk_out("lu_stall", 4'b0010);
        step(); idle();
        chk_out("lu_release", 4'b1100);
        check_eq("lu_stallcnt", 32'(StallCnt), 32'd1);

        // lw then dependent taken beq: two stalls, then squash.
        do_reset();
        Branch_id = 1'b1; BranchTaken_id = 1'b1; UsesRt_id = 1'b1; RtAddr_id = 5'd2;
        ex_lw(5'd2);
        chk_out("br_stall1", 4'b0010);
        step();
        MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0; MemRead_mem = 1'b1; RegWriteAddr_mem = 5'd2;
        chk_out("br_stall2", 4'b0010);
        step();
        MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;
        chk_out("br_taken_flush", 4'b1101);
        check_eq("br_stallcnt", 32'(StallCnt), 32'd2);
        step(); idle();
        chk_out("br_done", 4'b1100);
        check_eq("br_flushcnt", 32'(FlushCnt), 32'd1);

        // Branch depending on a load in MEM only: single stall.
        Branch_id = 1'b1; RsAddr_id = 5'd4; MemRead_mem = 1'b1; RegWriteAddr_mem = 5'd4;
        chk_out("brmem_stall", 4'b0010);
        step();
        MemRead_mem = 1'b0;
        chk_out("brmem_release", 4'b1100);
        check_eq("brmem_stallcnt", 32'(StallCnt), 32'd3);

        // $0 never matches.
        step(); idle();
        ex_lw(5'd0); RsAddr_id = 5'd0;
        chk_out("zero_reg", 4'b1100);

        // Rt only counts when the instruction actually reads it.
        step(); idle();
        ex_lw(5'd3); RtAddr_id = 5'd3; RsAddr_id = 5'd5;
        chk_out("rt_unused", 4'b1100);
        UsesRt_id = 1'b1;
        chk_out("rt_used", 4'b0010);
        MemRead_ex = 1'b0;
        chk_out("no_load", 4'b1100);

        // Hold while the second branch stall is pending.
        do_reset();
        Branch_id = 1'b1; BranchTaken_id = 1'b1; UsesRt_id = 1'b1; RtAddr_id = 5'd6;
        ex_lw(5'd6);
        chk_out("hold_pre_stall", 4'b0010);
        step();
        MemRead_ex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            Hold = 1'b1;
            chk_out("hold_out", 4'b0000);
            check_eq("hold_stallcnt", 32'(StallCnt), 32'd1);
        end
        step();
        Hold = 1'b0;
        chk_out("hold_resume", 4'b0010);
        check_eq("hold_resume_cnt", 32'(StallCnt), 32'd1);
        step();
        chk_out("hold_after_run", 4'b1101);
        check_eq("hold_final_cnt", 32'(StallCnt), 32'd2);

        // Hold beats a live hazard; a jump is not squashed during a stall.
        step(); idle();
        ex_lw(5'd1); RsAddr_id = 5'd1; Hold = 1'b1;
        chk_out("hold_over_hazard", 4'b0000);
        Hold = 1'b0; Jump_id = 1'b1;
        chk_out("jump_in_stall", 4'b0010);
        step(); idle();
        Jump_id = 1'b1;
        chk_out("jump_flush", 4'b1101);

        // Saturation with CNT_W=2.
        do_reset();
        ex_lw(5'd1); RsAddr_id = 5'd1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk_out("sat_stall", 4'b0010);
        end
        step(); idle();
        #1;
        check_eq("sat_stallcnt16", 32'(StallCnt), 32'd5);
        check_eq("sat_stallcnt2", 32'(s_StallCnt), 32'd3);
        Jump_id = 1'b1;
        repeat (4) step();
        Jump_id = 1'b0;
        #1;
        check_eq("sat_flushcnt16", 32'(FlushCnt), 32'd4);
        check_eq("sat_flushcnt2", 32'(s_FlushCnt), 32'd3);

        // Reset in BSTALL aborts the pending stall.
        Branch_id = 1'b1; BranchTaken_id = 1'b1; UsesRt_id = 1'b1; RtAddr_id = 5'd7;
        ex_lw(5'd7);
        chk_out("rstb_stall1", 4'b0010);
        step();
        MemRead_ex = 1'b0;
        chk_out("rstb_bstall", 4'b0010);
        rst = 1'b1;
        chk_out("rstb_in_rst", 4'b1100);
        step();
        rst = 1'b0;
        idle();
        chk_out("rstb_run", 4'b1100);
        check_eq("rstb_stallcnt2", 32'(s_StallCnt), 32'd0);
        check_eq("rstb_stallcnt16", 32'(StallCnt), 32'd0);
        check_eq("rstb_flushcnt", 32'(FlushCnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard detection and stall controller for the 5-stage MIPS pipeline.
- Sits in ID, alongside the forwarding unit; drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID squash.
- Covers the cases forwarding cannot: lw followed by a dependent ALU op (1 stall), and lw followed by a dependent BEQ/BNE (2 stalls; ID forwarding only sources EX ALU result or WB).
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall/flush performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead_ex  in  1  instruction in EX is a load.
- RegWrite_ex  in  1  instruction in EX writes a register.
- RegWriteAddr_ex  in  5  destination of the EX instruction.
- MemRead_mem  in  1  instruction in MEM is a load.
- RegWriteAddr_mem  in  5  destination of the MEM instruction.
- RsAddr_id  in  5  Rs of the ID instruction.
- RtAddr_id  in  5  Rt of the ID instruction.
- UsesRt_id  in  1  ID instruction reads Rt as a source (R-type, sw, beq/bne).
- Branch_id  in  1  ID instruction is BEQ/BNE.
- BranchTaken_id  in  1  branch comparison in ID resolves taken.
- Jump_id  in  1  ID instruction is J/JAL.
- Hold  in  1  external freeze (e.g. memory wait); highest priority.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEXFlush  out  1  load ID/EX with a bubble (all control signals 0).
- IFIDFlush  out  1  squash the fetched instruction (IF/ID cleared to NOP).
- StallCnt  out  CNT_W  stall cycles since reset, saturating.
- FlushCnt  out  CNT_W  IF/ID squashes since reset, saturating.

Behaviour:
- Match definitions (register 0 never matches):
  - rsHit(addr) = addr!=0 && addr==RsAddr_id.
  - rtHit(addr) = addr!=0 && UsesRt_id && addr==RtAddr_id.
  - hitEX = MemRead_ex && (rsHit(RegWriteAddr_ex) || rtHit(RegWriteAddr_ex)).
  - hitMEM = MemRead_mem && (rsHit(RegWriteAddr_mem) || rtHit(RegWriteAddr_mem)).
- FSM states: RUN, BSTALL. Registered state; state resets to RUN.
- RUN:
  - loadUse = hitEX && !Branch_id → stall this cycle; next state RUN. The bubble clears the hazard.
  - brLoadEX = Branch_id && hitEX → stall this cycle; next state BSTALL.
  - brLoadMEM = Branch_id && hitMEM → stall this cycle; next state RUN.
  - Otherwise no stall.
- BSTALL: stall unconditionally for exactly one cycle, ignoring the hazard inputs; next state RUN.
- Stall cycle outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- Non-stall cycle outputs: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=(Branch_id&&BranchTaken_id)||Jump_id.
- A taken branch or jump is never flushed in a stall cycle; it is re-evaluated once the stall ends.
- Hold=1: PCWrite=0, IFIDWrite=0, IDEXFlush=0, IFIDFlush=0. FSM state, counters and the pending BSTALL are frozen, and the stall resumes after Hold drops.
- All outputs are combinational from state and inputs; zero-cycle latency to the current ID instruction.
- Counters:
  - StallCnt increments on every cycle with IDEXFlush=1.
  - FlushCnt increments on every cycle with IFIDFlush=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- While rst=1: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=0. On the following edge state=RUN, StallCnt=0, FlushCnt=0.
- Reset asserted in BSTALL aborts the pending stall; the next cycle is RUN.
- Simultaneous RUN hazards: brLoadEX takes precedence over brLoadMEM; at most one BSTALL per detection.

Test Plan:
- lw $1 in EX (MemRead_ex=1, RegWriteAddr_ex=1), ID add with Rs=1, Branch_id=0 → one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle all released; StallCnt=1.
- lw $2 in EX, ID beq with Rt=2, UsesRt_id=1, BranchTaken_id=1 → two stall cycles (RUN→BSTALL→RUN); third cycle IFIDFlush=1, PCWrite=1; StallCnt=2, FlushCnt=1.
- lw writing $0 in EX, ID reading Rs=0 → no stall; outputs 1,1,0,0.
- ID sw with Rt=3, UsesRt_id=0 path: R-format Rt=3 with UsesRt_id=0 against lw $3 in EX → no stall; with UsesRt_id=1 → one stall.
- Hold=1 asserted in BSTALL for 3 cycles → PCWrite=0, IDEXFlush=0, StallCnt unchanged; after Hold drops, one stall cycle then RUN.
- CNT_W=2, five load-use stalls → StallCnt=3 (saturated); rst pulse in BSTALL → StallCnt=0, next cycle PCWrite=1.
